pc_fetch_unit: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for the LC-3 datapath.

---
 rtl/pc_fetch_if.sv | 28 ++
 rtl/pc_fetch_unit.sv | 121 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_if.sv
// Fetch-unit signal bundle: PC load controls, memory fetch handshake and IR/PC results.
// master = fetch unit side, slave = control FSM / memory side.
interface pc_fetch_if;
   logic        fetch_start;
   logic        LD_PC;
   logic [1:0]  PCMUX;
   logic [15:0] PCFromBus;
   logic [15:0] PCFromAdder;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic [15:0] IR;
   logic        ir_valid;
   logic        fetch_err;
   logic        busy;
   logic [15:0] ADDR1FromPC;

   modport master (
      input  fetch_start, LD_PC, PCMUX, PCFromBus, PCFromAdder, mem_ack, mem_rdata,
      output mem_req, mem_addr, IR, ir_valid, fetch_err, busy, ADDR1FromPC
   );

   modport slave (
      output fetch_start, LD_PC, PCMUX, PCFromBus, PCFromAdder, mem_ack, mem_rdata,
      input  mem_req, mem_addr, IR, ir_valid, fetch_err, busy, ADDR1FromPC
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// LC-3 program counter and instruction-fetch sequencer: req/ack fetch at PC, latches IR,
// updates PC through PCMUX, defers PC loads that arrive mid-fetch into a one-entry pending slot.
module pc_fetch_unit #(
   parameter logic [15:0] PC_RESET = 16'h3000,
   parameter int unsigned TIMEOUT  = 255
) (
   input logic       clk,
   input logic       rst_n,
   pc_fetch_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state_r;
   logic [15:0] pc_r;
   logic [15:0] ir_r;
   logic [15:0] pend_r;
   logic        pend_v_r;
   logic [7:0]  cnt_r;
   logic        mem_req_r;
   logic        ir_valid_r;
   logic        fetch_err_r;

   logic [15:0] pc_inc_s;
   logic [15:0] sel_s;
   logic        ld_take_s;

   // PCMUX source selection; the reserved code holds the current PC
   always_comb begin
      pc_inc_s  = pc_r + 16'd1;
      ld_take_s = bus.LD_PC && (bus.PCMUX != 2'b11);
      sel_s     = pc_r;
      case (bus.PCMUX)
         2'b00:   sel_s = pc_inc_s;
         2'b01:   sel_s = bus.PCFromBus;
         2'b10:   sel_s = bus.PCFromAdder;
         default: sel_s = pc_r;
      endcase
   end

   // Fetch FSM with PC, IR, pending-load and wait-counter state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pc_r        <= PC_RESET;
         ir_r        <= 16'h0000;
         pend_r      <= 16'h0000;
         pend_v_r    <= 1'b0;
         cnt_r       <= 8'd0;
         mem_req_r   <= 1'b0;
         ir_valid_r  <= 1'b0;
         fetch_err_r <= 1'b0;
      end else begin
         ir_valid_r  <= 1'b0;
         fetch_err_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (bus.LD_PC) begin
                  pc_r <= sel_s;
               end
               if (bus.fetch_start) begin
                  state_r   <= ST_REQ;
                  mem_req_r <= 1'b1;
                  cnt_r     <= 8'd0;
               end else begin
                  state_r   <= ST_IDLE;
                  mem_req_r <= 1'b0;
               end
            end
            ST_REQ: begin
               // PC stays frozen while mem_addr must be stable; loads land only on exit
               if (bus.mem_ack || (cnt_r == TO_LAST)) begin
                  if (ld_take_s) begin
                     pc_r <= sel_s;
                  end else if (pend_v_r) begin
                     pc_r <= pend_r;
                  end else if (bus.mem_ack) begin
                     pc_r <= pc_inc_s;
                  end
                  pend_v_r  <= 1'b0;
                  mem_req_r <= 1'b0;
                  if (bus.mem_ack) begin
                     ir_r       <= bus.mem_rdata;
                     ir_valid_r <= 1'b1;
                     state_r    <= ST_DONE;
                  end else begin
                     fetch_err_r <= 1'b1;
                     state_r     <= ST_IDLE;
                  end
               end else begin
                  cnt_r <= cnt_r + 8'd1;
                  if (ld_take_s) begin
                     pend_r   <= sel_s;
                     pend_v_r <= 1'b1;
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               mem_req_r <= 1'b0;
               pend_v_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_req     = mem_req_r;
   assign bus.mem_addr    = pc_r;
   assign bus.ADDR1FromPC = pc_r;
   assign bus.IR          = ir_r;
   assign bus.ir_valid    = ir_valid_r;
   assign bus.fetch_err   = fetch_err_r;
   assign bus.busy        = (state_r == ST_REQ);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed plus randomized bench for pc_fetch_unit; expectations come from a
// transaction-level model of PC/IR tracked as plain variables.
module tb_pc_fetch_unit;
   logic clk;
   logic rst_n;
   pc_fetch_if fif ();

   pc_fetch_unit #(.PC_RESET(16'h3000), .TIMEOUT(255)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (fif.master)
   );

   int vectors;
   int miscompares;
   logic [15:0] m_pc;
   logic [15:0] m_ir;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] pick(input logic [1:0] mux, input logic [15:0] cur,
                                        input logic [15:0] val);
      if (mux == 2'd0) return cur + 16'd1;
      if (mux == 2'd3) return cur;
      return val;
   endfunction

   task automatic drive_src(input logic [1:0] mux, input logic [15:0] val);
      fif.PCMUX       = mux;
      fif.PCFromBus   = (mux == 2'd1) ? val : 16'($urandom);
      fif.PCFromAdder = (mux == 2'd2) ? val : 16'($urandom);
   endtask

   task automatic idle_load(input logic [1:0] mux, input logic [15:0] val);
      fif.LD_PC = 1'b1;
      drive_src(mux, val);
      tick();
      fif.LD_PC = 1'b0;
      m_pc = pick(mux, m_pc, val);
      chk16("idle_load_pc", fif.ADDR1FromPC, m_pc);
      chk1("idle_load_noreq", fif.mem_req, 1'b0);
   endtask

   // One fetch; optional PC load alongside fetch_start and optional load in REQ cycle ld_at
   task automatic fetch(input int waits, input logic [15:0] rdata,
                        input bit pre_ld, input logic [1:0] pre_mux, input logic [15:0] pre_val,
                        input int ld_at, input logic [1:0] ld_mux, input logic [15:0] ld_val);
      logic [15:0] nxt;
      fif.fetch_start = 1'b1;
      fif.LD_PC = pre_ld;
      drive_src(pre_mux, pre_val);
      tick();
      fif.fetch_start = 1'b0;
      fif.LD_PC = 1'b0;
      if (pre_ld) m_pc = pick(pre_mux, m_pc, pre_val);
      nxt = m_pc + 16'd1;
      for (int c = 1; c <= waits + 1; c++) begin
         chk1("req_mem_req", fif.mem_req, 1'b1);
         chk1("req_busy", fif.busy, 1'b1);
         chk16("req_mem_addr", fif.mem_addr, m_pc);
         chk16("req_addr1", fif.ADDR1FromPC, m_pc);
         if (c == ld_at) begin
            fif.LD_PC = 1'b1;
            drive_src(ld_mux, ld_val);
            if (ld_mux != 2'd3) nxt = pick(ld_mux, m_pc, ld_val);
         end
         if (c == waits + 1) begin
            fif.mem_ack   = 1'b1;
            fif.mem_rdata = rdata;
         end
         tick();
         fif.LD_PC   = 1'b0;
         fif.mem_ack = 1'b0;
      end
      m_pc = nxt;
      m_ir = rdata;
      chk1("done_ir_valid", fif.ir_valid, 1'b1);
      chk16("done_ir", fif.IR, m_ir);
      chk16("done_pc", fif.ADDR1FromPC, m_pc);
      chk1("done_mem_req", fif.mem_req, 1'b0);
      tick();
      chk1("after_ir_valid", fif.ir_valid, 1'b0);
      chk1("after_busy", fif.busy, 1'b0);
   endtask

   task automatic timeout_run(input int ld_at, input logic [1:0] ld_mux, input logic [15:0] ld_val);
      int hi;
      logic [15:0] nxt;
      hi = 0;
      nxt = m_pc;
      fif.fetch_start = 1'b1;
      tick();
      fif.fetch_start = 1'b0;
      for (int c = 1; c <= 300; c++) begin
         if (fif.mem_req !== 1'b1) break;
         hi++;
         if (c == ld_at) begin
            fif.LD_PC = 1'b1;
            drive_src(ld_mux, ld_val);
            if (ld_mux != 2'd3) nxt = pick(ld_mux, m_pc, ld_val);
         end
         tick();
         fif.LD_PC = 1'b0;
      end
      chk16("to_req_cycles", 16'(hi), 16'd255);
      chk1("to_fetch_err", fif.fetch_err, 1'b1);
      chk1("to_busy", fif.busy, 1'b0);
      m_pc = nxt;
      chk16("to_pc", fif.ADDR1FromPC, m_pc);
      chk16("to_ir", fif.IR, m_ir);
      tick();
      chk1("to_err_pulse", fif.fetch_err, 1'b0);
      chk1("to_no_valid", fif.ir_valid, 1'b0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      fif.fetch_start = 1'b0;
      fif.LD_PC = 1'b0;
      fif.PCMUX = 2'd0;
      fif.PCFromBus = 16'h0000;
      fif.PCFromAdder = 16'h0000;
      fif.mem_ack = 1'b0;
      fif.mem_rdata = 16'h0000;
      m_pc = 16'h3000;
      m_ir = 16'h0000;
      tick();
      tick();
      chk16("rst_pc", fif.ADDR1FromPC, 16'h3000);
      chk16("rst_ir", fif.IR, 16'h0000);
      chk1("rst_req", fif.mem_req, 1'b0);
      chk1("rst_valid", fif.ir_valid, 1'b0);
      chk1("rst_err", fif.fetch_err, 1'b0);
      chk1("rst_busy", fif.busy, 1'b0);
      rst_n = 1'b1;
      tick();

      // Basic fetch, ack on the 4th REQ cycle
      fetch(3, 16'h1234, 1'b0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
      // Load from adder together with fetch_start
      fetch(1, 16'hBEEF, 1'b1, 2'd2, 16'h4050, 0, 2'd0, 16'h0000);
      // Bus load during REQ overrides PC+1
      fetch(4, 16'h5555, 1'b0, 2'd0, 16'h0000, 2, 2'd1, 16'h0200);
      // Load in the ack cycle wins; reserved code in REQ is a no-op
      fetch(2, 16'h0F0F, 1'b0, 2'd0, 16'h0000, 3, 2'd2, 16'h7777);
      fetch(2, 16'hA5A5, 1'b0, 2'd0, 16'h0000, 2, 2'd3, 16'h9999);
      // PC wrap
      idle_load(2'd1, 16'hFFFF);
      fetch(0, 16'h0001, 1'b0, 2'd0, 16'h0000, 0, 2'd0, 16'h0000);
      chk16("wrap_pc", fif.ADDR1FromPC, 16'h0000);
      idle_load(2'd3, 16'h1111);
      idle_load(2'd0, 16'h0000);

      // Timeouts, plain and with a pending load applied
      timeout_run(0, 2'd0, 16'h0000);
      timeout_run(10, 2'd2, 16'h6000);

      for (int i = 0; i < 25; i++) begin
         int w;
         w = int'($urandom_range(0, 6));
         if ($urandom_range(0, 3) == 0) idle_load(2'($urandom), 16'($urandom));
         fetch(w, 16'($urandom), 1'($urandom), 2'($urandom), 16'($urandom),
               int'($urandom_range(0, 7)), 2'($urandom), 16'($urandom));
      end

      // Reset two cycles into REQ, with a late ack
      idle_load(2'd1, 16'h4444);
      fif.fetch_start = 1'b1;
      tick();
      fif.fetch_start = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      chk1("midrst_req", fif.mem_req, 1'b0);
      chk1("midrst_busy", fif.busy, 1'b0);
      chk16("midrst_pc", fif.ADDR1FromPC, 16'h3000);
      chk16("midrst_ir", fif.IR, 16'h0000);
      fif.mem_ack = 1'b1;
      fif.mem_rdata = 16'hDEAD;
      tick();
      rst_n = 1'b1;
      tick();
      fif.mem_ack = 1'b0;
      tick();
      chk16("late_ack_ir", fif.IR, 16'h0000);
      chk16("late_ack_pc", fif.ADDR1FromPC, 16'h3000);
      chk1("late_ack_valid", fif.ir_valid, 1'b0);
      chk1("late_ack_req", fif.mem_req, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
